// File: rtl/integral_pkg.sv
// Shared constants and types for the integral-image read path.
// The tag space covers up to eight readers plus the compute engine.
package integral_pkg;

  localparam int VID_IN_WIDTH  = 320;
  localparam int VID_IN_HEIGHT = 240;
  localparam int FRAME_WORDS   = VID_IN_WIDTH * VID_IN_HEIGHT;
  localparam int ADDR_W        = 17;
  localparam int DATA_W        = 25;
  localparam int MAX_REQ       = 8;
  localparam int TAG_W         = $clog2(MAX_REQ + 1);

  // Tags 0..NUM_REQ-1 name a reader; NUM_REQ names the compute engine.
  function automatic logic [TAG_W-1:0] eng_tag(input int num_req);
    return TAG_W'(num_req);
  endfunction

  typedef struct packed {
    logic             valid;
    logic             oob;
    logic [TAG_W-1:0] tag;
  } issue_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr (cyclic),
// plus the pointer value that follows the winner.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic [IDX_W-1:0] next_ptr
);

  int   scan_idx;
  logic found;

  // NOTE: every output gets a default before the scan so no path leaves a
  // value unassigned; a missing default here would infer a latch.
  always_comb begin
    grant    = '0;
    winner   = '0;
    next_ptr = ptr;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = (int'(ptr) + k) % N;
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        winner          = IDX_W'(scan_idx);
        next_ptr        = (scan_idx == N - 1) ? '0 : IDX_W'(scan_idx + 1);
      end
    end
  end

endmodule

// File: rtl/integral_rd_arbiter.sv
// Shares the integral M10K read port: compute engine has absolute priority,
// readers are served round-robin only while a finished frame is valid.
module integral_rd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = integral_pkg::ADDR_W,
  parameter int DATA_W      = integral_pkg::DATA_W,
  parameter int FRAME_WORDS = integral_pkg::FRAME_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      eng_rd_req,
  input  logic [ADDR_W-1:0]         eng_rd_addr,
  output logic                      eng_rsp_valid,
  input  logic                      frame_valid,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic                      err_oob
);

  import integral_pkg::*;

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam logic [TAG_W-1:0] ENG_TAG = eng_tag(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, rr_winner, rr_next;
  logic [NUM_REQ-1:0] rr_req, rr_grant;
  logic [ADDR_W-1:0]  mem_rd_addr_q, mem_rd_addr_d, win_addr;
  logic               issue, rd_go, win_oob;
  issue_t             s1_q, s1_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               eng_rsp_valid_q, eng_rsp_valid_d;
  logic               s2_oob_q, s2_oob_d;
  logic               err_oob_q, err_oob_d;

  assign rr_req = frame_valid ? req_valid : '0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req      (rr_req),
    .ptr      (rr_ptr_q),
    .grant    (rr_grant),
    .winner   (rr_winner),
    .next_ptr (rr_next)
  );

  always_comb begin
    req_ready = (eng_rd_req || !reset) ? '0 : rr_grant;
    rd_go     = |req_ready;
    issue     = eng_rd_req || rd_go;
    win_addr  = eng_rd_req ? eng_rd_addr : req_addr[int'(rr_winner)*ADDR_W +: ADDR_W];
    win_oob   = 32'(win_addr) >= FRAME_WORDS;

    // Out-of-range reads still occupy a slot but never reach past the frame.
    mem_rd_addr_d = mem_rd_addr_q;
    if (issue) mem_rd_addr_d = win_oob ? '0 : win_addr;

    s1_d.valid = issue;
    s1_d.oob   = win_oob;
    s1_d.tag   = eng_rd_req ? ENG_TAG : TAG_W'(rr_winner);

    rr_ptr_d = rd_go ? rr_next : rr_ptr_q;

    // Second stage lines up with the M10K output register.
    eng_rsp_valid_d = s1_q.valid && (s1_q.tag == ENG_TAG);
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_d[i] = s1_q.valid && (s1_q.tag == TAG_W'(i));
    s2_oob_d  = s1_q.oob;
    err_oob_d = err_oob_q || (issue && win_oob);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q        <= '0;
      mem_rd_addr_q   <= '0;
      s1_q            <= '0;
      rsp_valid_q     <= '0;
      eng_rsp_valid_q <= 1'b0;
      s2_oob_q        <= 1'b0;
      err_oob_q       <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      s1_q            <= s1_d;
      rsp_valid_q     <= rsp_valid_d;
      eng_rsp_valid_q <= eng_rsp_valid_d;
      s2_oob_q        <= s2_oob_d;
      err_oob_q       <= err_oob_d;
    end
  end

  assign mem_rd_addr   = mem_rd_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign eng_rsp_valid = eng_rsp_valid_q;
  assign err_oob       = err_oob_q;
  assign rsp_data      = s2_oob_q ? '0 : mem_rd_data;

endmodule

// File: tb/tb_integral_rd_arbiter.sv
// Directed and soak tests for integral_rd_arbiter with a behavioural M10K
// holding mem[k] = k and a small arbitration/response model.
module tb_integral_rd_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 17;
  localparam int DW  = 25;
  localparam int FW  = 76800;
  localparam int ENG = NR;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             eng_rd_req = 1'b0;
  logic [AW-1:0]    eng_rd_addr = '0;
  logic             eng_rsp_valid;
  logic             frame_valid = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [AW-1:0]    mem_rd_addr;
  logic [DW-1:0]    mem_rd_data = '0;
  logic             err_oob;

  integral_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset),
    .eng_rd_req(eng_rd_req), .eng_rd_addr(eng_rd_addr), .eng_rsp_valid(eng_rsp_valid),
    .frame_valid(frame_valid), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .err_oob(err_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rd_data <= DW'(mem_rd_addr);

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: p0 = granted last cycle, p1 = granted two cycles ago.
  int            m_ptr;
  logic          m_err;
  logic          p0_v, p1_v;
  int            p0_tag, p1_tag;
  logic [DW-1:0] p0_data, p1_data;

  // Observed and expected values of the most recent tick.
  logic [NR-1:0] obs_ready, obs_rsp, exp_ready, exp_rsp;
  logic          obs_eng, obs_err, exp_eng, exp_err;
  logic [DW-1:0] obs_data, exp_data;
  logic [AW-1:0] obs_addr;

  function automatic logic [NR*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_err = 1'b0;
    p0_v = 1'b0; p1_v = 1'b0; p0_tag = 0; p1_tag = 0; p0_data = '0; p1_data = '0;
  endtask

  // Called at posedge+1: drives one cycle, samples at posedge+3, advances model.
  task automatic tick(input logic eng, input logic [AW-1:0] ea, input logic fv,
                      input logic [NR-1:0] rv, input logic [NR*AW-1:0] ra);
    logic          n_v;
    int            n_tag;
    logic [AW-1:0] n_addr;
    eng_rd_req = eng; eng_rd_addr = ea; frame_valid = fv; req_valid = rv; req_addr = ra;
    #2;
    exp_ready = '0;
    if (!eng && fv)
      for (int k = 0; k < NR; k++)
        if (rv[(m_ptr + k) % NR] && exp_ready == '0) exp_ready[(m_ptr + k) % NR] = 1'b1;
    exp_eng  = p1_v && (p1_tag == ENG);
    exp_rsp  = (p1_v && p1_tag < NR) ? NR'(1 << p1_tag) : '0;
    exp_data = p1_data;
    exp_err  = m_err;
    obs_ready = req_ready; obs_rsp = rsp_valid; obs_eng = eng_rsp_valid;
    obs_data  = rsp_data;  obs_err = err_oob;   obs_addr = mem_rd_addr;
    n_v = eng || (exp_ready != '0);
    n_tag = ENG; n_addr = ea;
    if (!eng)
      for (int i = 0; i < NR; i++)
        if (exp_ready[i]) begin n_tag = i; n_addr = ra[i*AW +: AW]; m_ptr = (i + 1) % NR; end
    p1_v = p0_v; p1_tag = p0_tag; p1_data = p0_data;
    p0_v = n_v;  p0_tag = n_tag;
    p0_data = (int'(n_addr) >= FW) ? '0 : DW'(n_addr);
    if (n_v && int'(n_addr) >= FW) m_err = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; eng_rd_req = 1'b0; req_valid = '0; frame_valid = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1; frame_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (mem_rd_addr !== '0) $display("FAIL reset_addr: got %0d want 0", mem_rd_addr); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_checks++; if (eng_rsp_valid !== 1'b0) $display("FAIL reset_eng_valid: got %b want 0", eng_rsp_valid); else n_pass++;
    n_checks++; if (err_oob !== 1'b0) $display("FAIL reset_err: got %b want 0", err_oob); else n_pass++;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_engine_priority();
    logic [NR*AW-1:0] ra = pack4(0, 0, 5, 0);
    tick(1'b1, 17'd641, 1'b1, 4'b0100, ra);
    n_checks++; if (obs_ready !== 4'b0000) $display("FAIL prio_ready_eng: got %b want 0000", obs_ready); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0100, ra);
    n_checks++; if (obs_ready !== 4'b0100) $display("FAIL prio_ready_retry: got %b want 0100", obs_ready); else n_pass++;
    n_checks++; if (obs_addr !== 17'd641) $display("FAIL prio_addr_eng: got %0d want 641", obs_addr); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, ra);
    n_checks++; if (obs_eng !== 1'b1 || obs_rsp !== 4'b0000) $display("FAIL prio_eng_rsp: got eng=%b rsp=%b want eng=1 rsp=0000", obs_eng, obs_rsp); else n_pass++;
    n_checks++; if (obs_data !== 25'd641) $display("FAIL prio_eng_data: got %0d want 641", obs_data); else n_pass++;
    n_checks++; if (obs_addr !== 17'd5) $display("FAIL prio_addr_rd: got %0d want 5", obs_addr); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, ra);
    n_checks++; if (obs_rsp !== 4'b0100 || obs_eng !== 1'b0) $display("FAIL prio_rd_rsp: got rsp=%b eng=%b want rsp=0100 eng=0", obs_rsp, obs_eng); else n_pass++;
    n_checks++; if (obs_data !== 25'd5) $display("FAIL prio_rd_data: got %0d want 5", obs_data); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want_ready, want_rsp;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      tick(1'b0, '0, 1'b1, (k < 12) ? 4'b1111 : 4'b0000, pack4(100, 101, 102, 103));
      want_ready = (k < 12) ? NR'(1 << (k % 4)) : '0;
      want_rsp   = (k >= 2) ? NR'(1 << ((k - 2) % 4)) : '0;
      n_checks++; if (obs_ready !== want_ready) $display("FAIL rr_ready[%0d]: got %b want %b", k, obs_ready, want_ready); else n_pass++;
      n_checks++; if (obs_rsp !== want_rsp || obs_eng !== 1'b0) $display("FAIL rr_rsp[%0d]: got %b eng=%b want %b eng=0", k, obs_rsp, obs_eng, want_rsp); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (obs_data !== DW'(100 + (k - 2) % 4)) $display("FAIL rr_data[%0d]: got %0d want %0d", k, obs_data, 100 + (k - 2) % 4); else n_pass++;
      end
    end
  endtask

  task automatic test_frame_gate();
    logic [NR*AW-1:0] ra = pack4(60, 61, 62, 63);
    apply_reset();
    tick(1'b0, '0, 1'b1, 4'b1000, pack4(0, 0, 0, 50));
    n_checks++; if (obs_ready !== 4'b1000) $display("FAIL gate_pre_ready: got %b want 1000", obs_ready); else n_pass++;
    for (int k = 0; k < 100; k++) begin
      tick(k % 10 == 5, AW'(2000 + k), 1'b0, 4'b1111, ra);
      n_checks++; if (obs_ready !== '0) $display("FAIL gate_ready[%0d]: got %b want 0000", k, obs_ready); else n_pass++;
      n_checks++; if (obs_rsp !== exp_rsp || obs_eng !== exp_eng) $display("FAIL gate_rsp[%0d]: got %b eng=%b want %b eng=%b", k, obs_rsp, obs_eng, exp_rsp, exp_eng); else n_pass++;
      if (exp_eng || exp_rsp != '0) begin
        n_checks++; if (obs_data !== exp_data) $display("FAIL gate_data[%0d]: got %0d want %0d", k, obs_data, exp_data); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (obs_rsp !== 4'b1000 || obs_data !== 25'd50) $display("FAIL gate_inflight: got %b/%0d want 1000/50", obs_rsp, obs_data); else n_pass++;
      end
    end
    tick(1'b0, '0, 1'b1, 4'b1111, ra);
    n_checks++; if (obs_ready !== 4'b0001) $display("FAIL gate_reopen: got %b want 0001", obs_ready); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, ra);
    tick(1'b0, '0, 1'b1, 4'b0000, ra);
    n_checks++; if (obs_rsp !== 4'b0001 || obs_data !== 25'd60) $display("FAIL gate_reopen_rsp: got %b/%0d want 0001/60", obs_rsp, obs_data); else n_pass++;
  endtask

  task automatic test_oob();
    tick(1'b0, '0, 1'b1, 4'b0010, pack4(0, 76800, 0, 0));
    n_checks++; if (obs_ready !== 4'b0010) $display("FAIL oob_ready: got %b want 0010", obs_ready); else n_pass++;
    n_checks++; if (obs_err !== 1'b0) $display("FAIL oob_err_before: got %b want 0", obs_err); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    n_checks++; if (obs_addr !== '0) $display("FAIL oob_mem_addr: got %0d want 0", obs_addr); else n_pass++;
    n_checks++; if (obs_err !== 1'b1) $display("FAIL oob_err_set: got %b want 1", obs_err); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    n_checks++; if (obs_rsp !== 4'b0010 || obs_data !== '0) $display("FAIL oob_rsp: got %b/%0d want 0010/0", obs_rsp, obs_data); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0010, pack4(0, 76799, 0, 0));
    n_checks++; if (obs_ready !== 4'b0010) $display("FAIL oob_edge_ready: got %b want 0010", obs_ready); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    n_checks++; if (obs_addr !== 17'd76799) $display("FAIL oob_edge_addr: got %0d want 76799", obs_addr); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    n_checks++; if (obs_rsp !== 4'b0010 || obs_data !== 25'd76799) $display("FAIL oob_edge_rsp: got %b/%0d want 0010/76799", obs_rsp, obs_data); else n_pass++;
    n_checks++; if (obs_err !== 1'b1) $display("FAIL oob_err_sticky: got %b want 1", obs_err); else n_pass++;
    tick(1'b1, 17'd131071, 1'b1, 4'b0000, '0);
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    n_checks++; if (obs_eng !== 1'b1 || obs_data !== '0) $display("FAIL oob_eng_rsp: got %b/%0d want 1/0", obs_eng, obs_data); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    tick(1'b0, '0, 1'b1, 4'b0010, pack4(0, 9, 0, 0));
    n_checks++; if (obs_ready !== 4'b0010) $display("FAIL mid_grant: got %b want 0010", obs_ready); else n_pass++;
    req_valid = 4'b1111; frame_valid = 1'b1; eng_rd_req = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (mem_rd_addr !== '0) $display("FAIL mid_addr: got %0d want 0", mem_rd_addr); else n_pass++;
    n_checks++; if (rsp_valid !== '0 || eng_rsp_valid !== 1'b0) $display("FAIL mid_rsp: got %b eng=%b want 0000 eng=0", rsp_valid, eng_rsp_valid); else n_pass++;
    n_checks++; if (err_oob !== 1'b0) $display("FAIL mid_err: got %b want 0", err_oob); else n_pass++;
    n_checks++; if (req_ready !== '0) $display("FAIL mid_ready: got %b want 0000", req_ready); else n_pass++;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b1, 4'b0000, '0);
      n_checks++; if (obs_rsp !== '0 || obs_eng !== 1'b0) $display("FAIL mid_no_rsp[%0d]: got %b eng=%b want 0000 eng=0", k, obs_rsp, obs_eng); else n_pass++;
    end
    tick(1'b0, '0, 1'b1, 4'b1111, pack4(1, 2, 3, 4));
    n_checks++; if (obs_ready !== 4'b0001) $display("FAIL mid_ptr: got %b want 0001", obs_ready); else n_pass++;
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
    tick(1'b0, '0, 1'b1, 4'b0000, '0);
  endtask

  task automatic test_soak();
    logic [NR-1:0] rv;
    logic [AW-1:0] ra [NR];
    int            wait_cnt [NR];
    logic [NR*AW-1:0] packed_ra;
    logic          eng;
    logic [AW-1:0] ea;
    apply_reset();
    rv = '0;
    for (int i = 0; i < NR; i++) begin ra[i] = '0; wait_cnt[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1; wait_cnt[i] = 0;
          ra[i] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(FW, 131071)) : AW'($urandom_range(0, FW - 1));
        end else if (rv[i] && $urandom_range(0, 19) == 0) begin
          rv[i] = 1'b0;
        end
      end
      packed_ra = '0;
      for (int i = 0; i < NR; i++) packed_ra[i*AW +: AW] = ra[i];
      eng = (c % 6 == 0);
      ea  = ($urandom_range(0, 31) == 0) ? AW'($urandom_range(FW, 131071)) : AW'($urandom_range(0, FW - 1));
      tick(eng, ea, 1'b1, rv, packed_ra);
      n_checks++; if (obs_ready !== exp_ready) $display("FAIL soak_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); else n_pass++;
      n_checks++; if (obs_rsp !== exp_rsp || obs_eng !== exp_eng) $display("FAIL soak_rsp[%0d]: got %b eng=%b want %b eng=%b", c, obs_rsp, obs_eng, exp_rsp, exp_eng); else n_pass++;
      if (exp_eng || exp_rsp != '0) begin
        n_checks++; if (obs_data !== exp_data) $display("FAIL soak_data[%0d]: got %0d want %0d", c, obs_data, exp_data); else n_pass++;
      end
      n_checks++; if (obs_err !== exp_err) $display("FAIL soak_err[%0d]: got %b want %b", c, obs_err, exp_err); else n_pass++;
      for (int i = 0; i < NR; i++) begin
        if (exp_ready[i]) begin
          n_checks++; if (wait_cnt[i] > 6 * NR) $display("FAIL soak_wait[%0d] reader %0d: got %0d want <= %0d", c, i, wait_cnt[i], 6 * NR); else n_pass++;
          rv[i] = 1'b0;
        end else if (rv[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, '0, 1'b1, '0, '0);
      n_checks++; if (obs_rsp !== exp_rsp || obs_eng !== exp_eng) $display("FAIL soak_drain[%0d]: got %b eng=%b want %b eng=%b", k, obs_rsp, obs_eng, exp_rsp, exp_eng); else n_pass++;
      if (exp_eng || exp_rsp != '0) begin
        n_checks++; if (obs_data !== exp_data) $display("FAIL soak_drain_data[%0d]: got %0d want %0d", k, obs_data, exp_data); else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_engine_priority();
    test_round_robin();
    test_frame_gate();
    test_oob();
    test_reset_midflight();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
